// File: rtl/frv_rng_lfsr.sv
// Request/response random number source: 32-bit Galois LFSR pool with seed/health tracking.
// One outstanding request; the op executes as the response is registered.
module frv_rng_lfsr #(
    parameter int unsigned SEED_THRESH  = 4,
    parameter int unsigned SAMPLE_LIMIT = 256,
    parameter int unsigned LATENCY      = 2
) (
    input  logic        g_clk,
    input  logic        g_reset,
    input  logic        rng_req_valid,
    input  logic [2:0]  rng_req_op,
    input  logic [31:0] rng_req_data,
    output logic        rng_req_ready,
    output logic        rng_rsp_valid,
    output logic [2:0]  rng_rsp_status,
    output logic [31:0] rng_rsp_data,
    input  logic        rng_rsp_ready
);

    localparam int unsigned LFSR_W = 32;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned SAMP_W = 16;
    localparam int unsigned STAT_W = 3;
    localparam int unsigned OP_W   = 3;

    localparam logic [LFSR_W-1:0] TAPS      = 32'h8020_0003;
    localparam logic [LFSR_W-1:0] POOL_INIT = 32'h0000_0001;

    localparam logic [STAT_W-1:0] ST_NO_INIT   = 3'd0;
    localparam logic [STAT_W-1:0] ST_UNHEALTHY = 3'd1;
    localparam logic [STAT_W-1:0] ST_HEALTHY   = 3'd2;

    localparam logic [OP_W-1:0] OP_SEED = 3'b001;
    localparam logic [OP_W-1:0] OP_SAMP = 3'b010;

    localparam logic [CNT_W-1:0]  SEED_MAX  = CNT_W'(SEED_THRESH);
    localparam logic [SAMP_W-1:0] SAMP_MAX  = SAMP_W'(SAMPLE_LIMIT);
    localparam logic [CNT_W-1:0]  LAT_LAST  = (LATENCY == 0) ? '0 : CNT_W'(LATENCY - 1);
    localparam bit                ZERO_LAT  = (LATENCY == 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RSP  = 2'd2
    } state_e;

    state_e              state_q;
    logic [CNT_W-1:0]    lat_cnt_q;
    logic [OP_W-1:0]     op_q;
    logic [LFSR_W-1:0]   data_q;
    logic [LFSR_W-1:0]   lfsr_q;
    logic [CNT_W-1:0]    seed_cnt_q;
    logic [SAMP_W-1:0]   samp_cnt_q;
    logic [STAT_W-1:0]   status_q;

    logic [LFSR_W-1:0]   lfsr_d;
    logic [CNT_W-1:0]    seed_cnt_d;
    logic [SAMP_W-1:0]   samp_cnt_d;
    logic [STAT_W-1:0]   status_d;
    logic [STAT_W-1:0]   rsp_status_d;
    logic [LFSR_W-1:0]   rsp_data_d;

    logic [OP_W-1:0]     exec_op;
    logic [LFSR_W-1:0]   exec_data;
    logic                exec_en;
    logic [LFSR_W-1:0]   lfsr_step;
    logic [LFSR_W-1:0]   seed_mix;
    logic [CNT_W-1:0]    seed_cnt_inc;
    logic [SAMP_W-1:0]   samp_cnt_inc;

    // With zero latency the op executes straight from the request inputs.
    always_comb begin
        exec_op   = (state_q == S_IDLE) ? rng_req_op   : op_q;
        exec_data = (state_q == S_IDLE) ? rng_req_data : data_q;
        exec_en   = (ZERO_LAT && (state_q == S_IDLE) && rng_req_valid) ||
                    ((state_q == S_BUSY) && (lat_cnt_q == LAT_LAST));
    end

    always_comb begin
        lfsr_step    = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
        seed_mix     = lfsr_q ^ exec_data;
        seed_cnt_inc = (seed_cnt_q >= SEED_MAX) ? seed_cnt_q : seed_cnt_q + CNT_W'(1);
        samp_cnt_inc = samp_cnt_q + SAMP_W'(1);

        lfsr_d       = lfsr_q;
        seed_cnt_d   = seed_cnt_q;
        samp_cnt_d   = samp_cnt_q;
        status_d     = status_q;
        rsp_status_d = status_q;
        rsp_data_d   = '0;

        case (exec_op)
            OP_SEED: begin
                lfsr_d     = (seed_mix == '0) ? POOL_INIT : seed_mix;
                seed_cnt_d = seed_cnt_inc;
                if (seed_cnt_inc == SEED_MAX) begin
                    status_d   = ST_HEALTHY;
                    samp_cnt_d = '0;
                end
                rsp_status_d = status_d;
            end
            OP_SAMP: begin
                // Status is reported pre-update so valid data always carries HEALTHY.
                if (status_q == ST_HEALTHY) begin
                    rsp_data_d   = lfsr_q;
                    rsp_status_d = ST_HEALTHY;
                    lfsr_d       = lfsr_step;
                    samp_cnt_d   = samp_cnt_inc;
                    if (samp_cnt_inc == SAMP_MAX) begin
                        status_d   = ST_UNHEALTHY;
                        seed_cnt_d = '0;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            state_q        <= S_IDLE;
            lat_cnt_q      <= '0;
            op_q           <= '0;
            data_q         <= '0;
            lfsr_q         <= POOL_INIT;
            seed_cnt_q     <= '0;
            samp_cnt_q     <= '0;
            status_q       <= ST_NO_INIT;
            rng_req_ready  <= 1'b1;
            rng_rsp_valid  <= 1'b0;
            rng_rsp_status <= ST_NO_INIT;
            rng_rsp_data   <= '0;
        end else begin
            if (exec_en) begin
                lfsr_q         <= lfsr_d;
                seed_cnt_q     <= seed_cnt_d;
                samp_cnt_q     <= samp_cnt_d;
                status_q       <= status_d;
                rng_rsp_status <= rsp_status_d;
                rng_rsp_data   <= rsp_data_d;
                rng_rsp_valid  <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (rng_req_valid) begin
                        op_q          <= rng_req_op;
                        data_q        <= rng_req_data;
                        lat_cnt_q     <= '0;
                        rng_req_ready <= 1'b0;
                        state_q       <= ZERO_LAT ? S_RSP : S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (lat_cnt_q == LAT_LAST) begin
                        state_q <= S_RSP;
                    end else begin
                        lat_cnt_q <= lat_cnt_q + CNT_W'(1);
                    end
                end
                S_RSP: begin
                    if (rng_rsp_ready) begin
                        rng_rsp_valid <= 1'b0;
                        rng_req_ready <= 1'b1;
                        state_q       <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frv_rng_lfsr.sv
// Bench for frv_rng_lfsr: directed literal scenarios followed by randomized traffic,
// with every cycle compared against a transaction-level model of the RNG.
module tb_frv_rng_lfsr;

    localparam int unsigned ST  = 4;
    localparam int unsigned SL  = 3;
    localparam int unsigned LAT = 2;

    logic        g_clk = 1'b0;
    logic        g_reset;
    logic        rng_req_valid;
    logic [2:0]  rng_req_op;
    logic [31:0] rng_req_data;
    logic        rng_req_ready;
    logic        rng_rsp_valid;
    logic [2:0]  rng_rsp_status;
    logic [31:0] rng_rsp_data;
    logic        rng_rsp_ready;

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    // Model: 0 idle, 1 waiting out latency, 2 response pending.
    int          m_phase = 0;
    int          m_wait  = 0;
    logic [31:0] m_pool  = 32'h1;
    int unsigned m_seeds = 0;
    int unsigned m_samps = 0;
    logic [2:0]  m_status = 3'd0;
    logic [31:0] m_exp_data = 32'h0;
    logic [2:0]  m_exp_status = 3'd0;

    frv_rng_lfsr #(
        .SEED_THRESH (ST),
        .SAMPLE_LIMIT(SL),
        .LATENCY     (LAT)
    ) dut (
        .g_clk         (g_clk),
        .g_reset       (g_reset),
        .rng_req_valid (rng_req_valid),
        .rng_req_op    (rng_req_op),
        .rng_req_data  (rng_req_data),
        .rng_req_ready (rng_req_ready),
        .rng_rsp_valid (rng_rsp_valid),
        .rng_rsp_status(rng_rsp_status),
        .rng_rsp_data  (rng_rsp_data),
        .rng_rsp_ready (rng_rsp_ready)
    );

    always #5 g_clk = ~g_clk;

    function automatic logic [31:0] step(input logic [31:0] v);
        return (v >> 1) ^ (v[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one accepted request to the pool/health state and record its response.
    task automatic model_exec(input logic [2:0] op, input logic [31:0] data);
        logic [31:0] p;
        m_exp_data   = 32'h0;
        m_exp_status = m_status;
        case (op)
            3'b001: begin
                p      = m_pool ^ data;
                m_pool = (p == 32'h0) ? 32'h1 : p;
                m_seeds = (m_seeds + 1 > ST) ? ST : m_seeds + 1;
                if (m_seeds == ST) begin
                    m_status = 3'd2;
                    m_samps  = 0;
                end
                m_exp_status = m_status;
            end
            3'b010: begin
                if (m_status == 3'd2) begin
                    m_exp_data = m_pool;
                    m_pool     = step(m_pool);
                    m_samps++;
                    if (m_samps == SL) begin
                        m_status = 3'd1;
                        m_seeds  = 0;
                    end
                end
            end
            default: begin
            end
        endcase
    endtask

    always @(posedge g_clk) begin
        if (g_reset) begin
            m_phase  = 0;
            m_pool   = 32'h1;
            m_seeds  = 0;
            m_samps  = 0;
            m_status = 3'd0;
        end else begin
            case (m_phase)
                0: if (rng_req_valid) begin
                    model_exec(rng_req_op, rng_req_data);
                    m_wait  = LAT;
                    m_phase = (m_wait == 0) ? 2 : 1;
                end
                1: begin
                    m_wait--;
                    if (m_wait == 0) m_phase = 2;
                end
                default: if (rng_rsp_ready) m_phase = 0;
            endcase
        end
    end

    always @(negedge g_clk) begin
        if (started) begin
            chk("req_ready", 32'(rng_req_ready), 32'(m_phase == 0));
            chk("rsp_valid", 32'(rng_rsp_valid), 32'(m_phase == 2));
            if (m_phase == 2) begin
                chk("rsp_data", rng_rsp_data, m_exp_data);
                chk("rsp_status", 32'(rng_rsp_status), 32'(m_exp_status));
            end
        end
    end

    task automatic do_reset();
        g_reset = 1'b1;
        @(negedge g_clk);
        g_reset = 1'b0;
    endtask

    task automatic do_req(input logic [2:0] op, input logic [31:0] data,
                          output int lat, output logic [2:0] st, output logic [31:0] d);
        int n;
        rng_req_valid = 1'b1;
        rng_req_op    = op;
        rng_req_data  = data;
        @(negedge g_clk);
        rng_req_valid = 1'b0;
        n = 1;
        while (!rng_rsp_valid && n < 40) begin
            @(negedge g_clk);
            n++;
        end
        if (!rng_rsp_valid) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout: no response within %0d cycles", n);
        end
        lat = n;
        st  = rng_rsp_status;
        d   = rng_rsp_data;
        rng_rsp_ready = 1'b1;
        @(negedge g_clk);
        rng_rsp_ready = 1'b0;
    endtask

    task automatic req_chk(input string name, input logic [2:0] op, input logic [31:0] data,
                           input logic [2:0] exp_st, input logic [31:0] exp_d);
        int lat;
        logic [2:0] st;
        logic [31:0] d;
        do_req(op, data, lat, st, d);
        chk({name, "_status"}, 32'(st), 32'(exp_st));
        chk({name, "_data"}, d, exp_d);
    endtask

    initial begin
        int lat;
        logic [2:0] st;
        logic [31:0] d;
        logic [31:0] held_d;
        logic [2:0] held_st;
        logic [2:0] seed_st [4];

        seed_st[0] = 3'd0; seed_st[1] = 3'd0; seed_st[2] = 3'd0; seed_st[3] = 3'd2;
        g_reset       = 1'b1;
        rng_req_valid = 1'b0;
        rng_req_op    = 3'b000;
        rng_req_data  = 32'h0;
        rng_rsp_ready = 1'b0;
        repeat (2) @(negedge g_clk);
        chk("reset_req_ready", 32'(rng_req_ready), 32'd1);
        chk("reset_rsp_valid", 32'(rng_rsp_valid), 32'd0);
        chk("reset_rsp_status", 32'(rng_rsp_status), 32'd0);
        chk("reset_rsp_data", rng_rsp_data, 32'h0);
        started = 1'b1;
        g_reset = 1'b0;

        do_req(3'b100, 32'hDEAD_BEEF, lat, st, d);
        chk("test_latency", 32'(lat), 32'd3);
        chk("test_status", 32'(st), 32'd0);
        chk("test_data", d, 32'h0);

        req_chk("samp_noinit", 3'b010, 32'h0, 3'd0, 32'h0);
        for (int i = 0; i < 4; i++) req_chk("seed_zero", 3'b001, 32'h0, seed_st[i], 32'h0);
        req_chk("samp1", 3'b010, 32'h0, 3'd2, 32'h0000_0001);
        req_chk("samp2", 3'b010, 32'h0, 3'd2, 32'h8020_0003);
        req_chk("samp3", 3'b010, 32'h0, 3'd2, 32'hC030_0002);
        req_chk("samp_exhausted", 3'b010, 32'h0, 3'd1, 32'h0);
        for (int i = 0; i < 4; i++)
            req_chk("reseed", 3'b001, 32'h0, (i == 3) ? 3'd2 : 3'd1, 32'h0);
        req_chk("samp_reseeded", 3'b010, 32'h0, 3'd2, 32'h6018_0001);
        req_chk("op_multi_hot", 3'b011, 32'h1234_5678, 3'd2, 32'h0);
        req_chk("op_zero", 3'b000, 32'h1234_5678, 3'd2, 32'h0);

        do_reset();
        req_chk("seed_one", 3'b001, 32'h0000_0001, 3'd0, 32'h0);
        for (int i = 1; i < 4; i++) req_chk("seed_after_one", 3'b001, 32'h0, seed_st[i], 32'h0);
        req_chk("samp_forced", 3'b010, 32'h0, 3'd2, 32'h0000_0001);

        // Backpressure: response must stay put and new requests must be dropped.
        rng_req_valid = 1'b1;
        rng_req_op    = 3'b010;
        @(negedge g_clk);
        rng_req_op    = 3'b001;
        rng_req_data  = 32'hA5A5_5A5A;
        for (int n = 0; n < 40 && !rng_rsp_valid; n++) @(negedge g_clk);
        held_d  = rng_rsp_data;
        held_st = rng_rsp_status;
        chk("hold_first_data", held_d, 32'h8020_0003);
        for (int i = 0; i < 10; i++) begin
            @(negedge g_clk);
            chk("hold_valid", 32'(rng_rsp_valid), 32'd1);
            chk("hold_data", rng_rsp_data, 32'h8020_0003);
            chk("hold_status", 32'(rng_rsp_status), 32'(held_st));
        end
        rng_req_valid = 1'b0;
        rng_rsp_ready = 1'b1;
        @(negedge g_clk);
        rng_rsp_ready = 1'b0;
        chk("release_req_ready", 32'(rng_req_ready), 32'd1);
        req_chk("samp_after_hold", 3'b010, 32'h0, 3'd2, 32'hC030_0002);

        do_reset();
        for (int i = 0; i < 3; i++) req_chk("pre_reset_seed", 3'b001, 32'h0, 3'd0, 32'h0);
        rng_req_valid = 1'b1;
        rng_req_op    = 3'b001;
        rng_req_data  = 32'h0;
        @(negedge g_clk);
        rng_req_valid = 1'b0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            chk("no_rsp_after_reset", 32'(rng_rsp_valid), 32'd0);
            @(negedge g_clk);
        end
        for (int i = 0; i < 3; i++) req_chk("post_reset_seed", 3'b001, 32'h0, 3'd0, 32'h0);

        // Randomized traffic with backpressure and occasional resets.
        for (int c = 0; c < 4000; c++) begin
            int r;
            r = int'($urandom_range(0, 9));
            rng_req_valid = ($urandom_range(0, 1) == 0);
            rng_req_op    = (r < 4) ? 3'b001 : (r < 8) ? 3'b010 : (r == 8) ? 3'b100
                                                                        : 3'($urandom_range(0, 7));
            rng_req_data  = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            rng_rsp_ready = ($urandom_range(0, 9) < 6);
            g_reset       = ($urandom_range(0, 299) == 0);
            @(negedge g_clk);
        end
        g_reset       = 1'b0;
        rng_req_valid = 1'b0;
        rng_rsp_ready = 1'b1;
        repeat (5) @(negedge g_clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
